// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and one shared memory slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  m0_req_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic                  m0_we_i;
  logic [BE_WIDTH-1:0]   m0_be_i;
  logic [DATA_WIDTH-1:0] m0_wdata_i;
  logic                  m0_gnt_o;
  logic                  m0_rvalid_o;
  logic [DATA_WIDTH-1:0] m0_rdata_o;
  logic                  m0_err_o;

  logic                  m1_req_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic                  m1_we_i;
  logic [BE_WIDTH-1:0]   m1_be_i;
  logic [DATA_WIDTH-1:0] m1_wdata_i;
  logic                  m1_gnt_o;
  logic                  m1_rvalid_o;
  logic [DATA_WIDTH-1:0] m1_rdata_o;
  logic                  m1_err_o;

  logic                  s_req_o;
  logic [ADDR_WIDTH-1:0] s_addr_o;
  logic                  s_we_o;
  logic [BE_WIDTH-1:0]   s_be_o;
  logic [DATA_WIDTH-1:0] s_wdata_o;
  logic                  s_gnt_i;
  logic                  s_rvalid_i;
  logic [DATA_WIDTH-1:0] s_rdata_i;
  logic                  s_err_i;

  logic                  protocol_err_o;

  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    input  s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i,
    output protocol_err_o
  );

  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    output s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i,
    input  protocol_err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter onto one memory port, with request locking during
// slave stalls and an owner FIFO that routes in-order responses back to their master.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  mem_port_arbiter_if.slave   bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);

  logic             sel_q;
  logic             locked_q;
  logic             last_winner_q;
  logic             protocol_err_q;
  logic             owner_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [1:0]            req;
  logic                  sel;
  logic                  lock_hold;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_head;
  logic                  s_req;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [BE_WIDTH-1:0]   be_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign req        = {bus.m1_req_i, bus.m0_req_i};
  assign fifo_full  = (count_q == FIFO_DEPTH);
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = owner_q[rd_ptr_q];

  // A lock only holds while its owner still requests; a master abandoning a stalled
  // request must not leave the other master blocked or get a phantom grant.
  assign lock_hold  = locked_q & req[sel_q];

  // NOTE: every path assigns sel after its default, so no latch is inferred.
  always_comb begin
    sel = sel_q;
    if (!lock_hold) begin
      if (&req)        sel = ~last_winner_q;
      else if (req[0]) sel = 1'b0;
      else if (req[1]) sel = 1'b1;
    end
  end

  // The full check uses the registered count, so a same-cycle pop frees a slot
  // only from the next cycle onward.
  assign s_req = (|req) & ~fifo_full;
  assign push  = s_req & bus.s_gnt_i;
  assign pop   = bus.s_rvalid_i & ~fifo_empty;

  assign addr_mux  = sel ? bus.m1_addr_i  : bus.m0_addr_i;
  assign be_mux    = sel ? bus.m1_be_i    : bus.m0_be_i;
  assign wdata_mux = sel ? bus.m1_wdata_i : bus.m0_wdata_i;

  assign bus.s_req_o   = s_req;
  assign bus.s_addr_o  = addr_mux;
  assign bus.s_we_o    = sel ? bus.m1_we_i : bus.m0_we_i;
  assign bus.s_be_o    = be_mux;
  assign bus.s_wdata_o = wdata_mux;

  assign bus.m0_gnt_o = push & ~sel;
  assign bus.m1_gnt_o = push &  sel;

  assign bus.m0_rvalid_o = pop & ~fifo_head;
  assign bus.m1_rvalid_o = pop &  fifo_head;
  assign bus.m0_err_o    = pop & bus.s_err_i & ~fifo_head;
  assign bus.m1_err_o    = pop & bus.s_err_i &  fifo_head;
  assign bus.m0_rdata_o  = bus.s_rdata_i;
  assign bus.m1_rdata_o  = bus.s_rdata_i;

  assign bus.protocol_err_o = protocol_err_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sel_q          <= 1'b0;
      locked_q       <= 1'b0;
      last_winner_q  <= 1'b1;
      protocol_err_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      sel_q <= sel;

      if (push) begin
        locked_q      <= 1'b0;
        last_winner_q <= sel;
      end else if (s_req) begin
        locked_q <= 1'b1;
      end else if (locked_q && !req[sel_q]) begin
        locked_q <= 1'b0;
      end

      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (bus.s_rvalid_i && fifo_empty) protocol_err_q <= 1'b1;
    end
  end

  // NOTE: owner storage has no reset; count and pointers guarantee no stale entry is read.
  always_ff @(posedge clk_i) begin
    if (push) owner_q[wr_ptr_q] <= sel;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning address width of all ports.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data width of all ports; byte-enable width = DATA_WIDTH/8.
REQ-003 The block SHALL have parameter MAX_OUTSTANDING, default 2, meaning depth of the response-owner FIFO (power of two, >=1).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk_i  input  1  clock, all state on rising edge; rst_ni  input  1  synchronous active-low reset.
REQ-005 The block SHALL provide, for each master port mN (N = 0 core data side, N = 1 trace/debug side), these signals:
- mN_req_i  input  1  request
- mN_addr_i  input  ADDR_WIDTH  address
- mN_we_i  input  1  write enable
- mN_be_i  input  DATA_WIDTH/8  byte enables
- mN_wdata_i  input  DATA_WIDTH  write data
- mN_gnt_o  output  1  grant
- mN_rvalid_o  output  1  response valid
- mN_rdata_o  output  DATA_WIDTH  read data
- mN_err_o  output  1  response error
REQ-006 The block SHALL provide these slave-side signals:
- s_req_o  output  1  request
- s_addr_o  output  ADDR_WIDTH  address
- s_we_o  output  1  write enable
- s_be_o  output  DATA_WIDTH/8  byte enables
- s_wdata_o  output  DATA_WIDTH  write data
- s_gnt_i  input  1  grant
- s_rvalid_i  input  1  response valid
- s_rdata_i  input  DATA_WIDTH  read data
- s_err_i  input  1  response error
REQ-007 The block SHALL provide protocol_err_o  output  1  sticky flag, set on an unexpected slave response.

Function
REQ-008 The block SHALL hold registered state: sel (current owner, 1 bit), locked (1 bit), last_winner (1 bit), an owner FIFO of MAX_OUTSTANDING entries with read/write pointers and a count, and protocol_err_o.
REQ-009 Arbitration SHALL be round-robin: when unlocked and both requests are high, the master not equal to last_winner wins; when only one request is high, that master wins.
REQ-010 s_req_o SHALL be (m0_req_i | m1_req_i) & !fifo_full; the s_addr_o, s_we_o, s_be_o and s_wdata_o signals SHALL be muxed combinationally from the selected master.
REQ-011 Request stability: if s_req_o is high and s_gnt_i is low, locked SHALL be set next cycle and sel held; while locked, the other master SHALL NOT be selected even if it requests.
REQ-012 mN_gnt_o SHALL equal s_gnt_i & s_req_o & (selected == N), in the same cycle with zero latency; the unselected master's gnt SHALL be 0.
REQ-013 On an accepted handshake (s_req_o & s_gnt_i), the block SHALL push the selected ID into the FIFO, set last_winner to the selected ID, and clear locked.
REQ-014 Responses SHALL be routed in order: mN_rvalid_o = s_rvalid_i & !fifo_empty & (fifo_head == N), combinationally; mN_err_o = s_err_i gated the same way; mN_rdata_o = s_rdata_i, broadcast unconditionally.
REQ-015 On s_rvalid_i with a non-empty FIFO, the block SHALL pop the FIFO.
REQ-016 A push and a pop in the same cycle SHALL leave the count unchanged, with both pointers advancing modulo MAX_OUTSTANDING.
REQ-017 While the FIFO is full, s_req_o SHALL be 0 and no grant SHALL be issued; a pop in the same cycle SHALL NOT unblock the request until the next cycle.
REQ-018 On s_rvalid_i with an empty FIFO, both rvalid outputs SHALL stay 0, no pop SHALL occur, and protocol_err_o SHALL set and remain set until reset.
REQ-019 A master dropping its request while locked SHALL clear locked; this is a protocol violation by the master, and the block SHALL tolerate it without corrupting the FIFO.

Reset
REQ-020 While rst_ni is sampled low, the block SHALL clear the FIFO (pointers and count = 0), set locked = 0, sel = 0, last_winner = 1 (so m0 wins the first tie) and protocol_err_o = 0.
REQ-021 Reset asserted mid-transaction SHALL discard all outstanding owner entries; responses arriving after reset SHALL trigger REQ-018.
REQ-022 During reset, combinational outputs SHALL follow the reset state: FIFO empty implies rvalid outputs are 0.

Verification
REQ-023 Tie: m0_req_i and m1_req_i high continuously, s_gnt_i = 1 -> grants alternate m0, m1, m0, m1 starting with m0 after reset.
REQ-024 Stall lock: m0 requests with s_gnt_i = 0 for 3 cycles while m1 requests from cycle 1 -> s_addr_o stays m0_addr_i; m0_gnt_o is asserted on the first s_gnt_i; m1 is granted on the next cycle.
REQ-025 Full: MAX_OUTSTANDING = 2, two granted reads with no rvalid -> s_req_o = 0 on the third request; after one s_rvalid_i, s_req_o = 1 on the following cycle.
REQ-026 Ordering: m0 read at 0x100 then m1 read at 0x200, responses 0xAAAA then 0xBBBB -> m0_rvalid_o with 0xAAAA first, then m1_rvalid_o with 0xBBBB.
REQ-027 Spurious response: s_rvalid_i with the FIFO empty -> no mN_rvalid_o, protocol_err_o = 1 until rst_ni is low for one cycle.
REQ-028 Reset mid-operation: one outstanding entry, then rst_ni = 0 for 1 cycle -> FIFO count = 0, and the next tie is granted to m0.
